// File: rtl/lcd_timing_controller_pkg.sv
// Shared LCD timing constants, PPU mode encoding and the fixed-length mode decode.
// PPU_VAR_XFER_EN adds the transfer-window bounds used by the variable-length mode 3.
package lcd_timing_controller_pkg;

  localparam logic [8:0] DotsPerLine   = 9'd456;
  localparam logic [8:0] DotLast       = DotsPerLine - 9'd1;
  localparam logic [8:0] OamDots       = 9'd80;
  localparam logic [8:0] XferDots      = 9'd172;
  localparam logic [8:0] XferEnd       = OamDots + XferDots;
  localparam logic [7:0] VisibleLines  = 8'd144;
  localparam logic [7:0] LinesPerFrame = 8'd154;
  localparam logic [7:0] LineLast      = LinesPerFrame - 8'd1;
`ifdef PPU_VAR_XFER_EN
  localparam logic [8:0] XferMinDot    = 9'd92;
  localparam logic [8:0] XferMaxDot    = 9'd369;
`endif

  // Encoding matches STAT.Mode[1:0] directly.
  typedef enum logic [1:0] {
    ModeHblank  = 2'd0,
    ModeVblank  = 2'd1,
    ModeOamScan = 2'd2,
    ModeXfer    = 2'd3
  } ppu_mode_e;

  function automatic ppu_mode_e fixed_mode(input logic [7:0] ly, input logic [8:0] dot);
    if (ly >= VisibleLines) return ModeVblank;
    if (dot < OamDots)      return ModeOamScan;
    if (dot < XferEnd)      return ModeXfer;
    return ModeHblank;
  endfunction

endpackage

// File: rtl/lcd_timing_controller_stat_irq_gen.sv
// STAT interrupt line: coincidence register, source OR and blocking rising-edge detector.
// Fed with the next-state mode so mode-driven requests line up with the mode change itself.
module lcd_timing_controller_stat_irq_gen
  import lcd_timing_controller_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       tick_i,
  input  ppu_mode_e  mode_i,
  input  logic [7:0] ly_i,
  input  logic [7:0] lyc_i,
  input  logic [3:0] stat_ie_i,
  output logic       coincidence_o,
  output logic       stat_irq_o
);

  logic coin_d, coin_q;
  logic line_d, line_q;
  logic irq_d, irq_q;

  always_comb begin
    coin_d = (ly_i == lyc_i);
    line_d = ((mode_i == ModeHblank)  & stat_ie_i[0]) |
             ((mode_i == ModeVblank)  & stat_ie_i[1]) |
             ((mode_i == ModeOamScan) & stat_ie_i[2]) |
             (coin_d & stat_ie_i[3]);
    // Edges seen while the dot clock is stalled or the LCD is off are absorbed.
    irq_d  = tick_i & line_d & ~line_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      coin_q <= 1'b0;
      line_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      coin_q <= coin_d;
      line_q <= line_d;
      irq_q  <= irq_d;
    end
  end

  assign coincidence_o = coin_q;
  assign stat_irq_o    = irq_q;

endmodule

// File: rtl/lcd_timing_controller.sv
// LCD scanline sequencer: dot/line counters, PPU mode, LY, interrupts and CPU VRAM/OAM gating.
// Define PPU_VAR_XFER_EN to end mode 3 on the fetcher's xfer_done instead of a fixed length.
module lcd_timing_controller
  import lcd_timing_controller_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       dot_en_i,
  input  logic       lcd_enable_i,
  input  logic [3:0] stat_ie_i,
  input  logic [7:0] lyc_i,
  input  logic       xfer_done_i,
  output logic [7:0] ly_o,
  output logic [1:0] mode_o,
  output logic       coincidence_o,
  output logic [8:0] dot_x_o,
  output logic [5:0] oam_index_o,
  output logic       line_start_o,
  output logic       stat_irq_o,
  output logic       vblank_irq_o,
  output logic       cpu_vram_ok_o,
  output logic       cpu_oam_ok_o
);

  logic      running_d, running_q;
  logic [7:0] ly_d, ly_q;
  logic [8:0] dot_d, dot_q;
  ppu_mode_e mode_d, mode_q;
  logic [5:0] oam_d, oam_q;
  logic      line_start_d, line_start_q;
  logic      vblank_d, vblank_q;
  logic      tick;

`ifdef PPU_VAR_XFER_EN
  logic xfer_hit, xfer_seen_d, xfer_seen_q;
  assign xfer_hit = xfer_done_i & (mode_q == ModeXfer) & (dot_q >= XferMinDot);
`else
  logic unused_xfer_done;
  assign unused_xfer_done = xfer_done_i;
`endif

  assign tick = dot_en_i & lcd_enable_i;

  always_comb begin
    running_d    = running_q;
    ly_d         = ly_q;
    dot_d        = dot_q;
    mode_d       = mode_q;
    oam_d        = oam_q;
    line_start_d = 1'b0;
    vblank_d     = 1'b0;
`ifdef PPU_VAR_XFER_EN
    xfer_seen_d  = xfer_seen_q | xfer_hit;
`endif
    if (!lcd_enable_i) begin
      running_d = 1'b0;
      ly_d      = 8'd0;
      dot_d     = 9'd0;
      mode_d    = ModeHblank;
      oam_d     = 6'd0;
`ifdef PPU_VAR_XFER_EN
      xfer_seen_d = 1'b0;
`endif
    end else if (dot_en_i) begin
      if (!running_q) begin
        // First tick after enable starts line 0 rather than advancing.
        running_d = 1'b1;
        ly_d      = 8'd0;
        dot_d     = 9'd0;
      end else if (dot_q == DotLast) begin
        dot_d    = 9'd0;
        ly_d     = (ly_q == LineLast) ? 8'd0 : ly_q + 8'd1;
        vblank_d = (ly_q == VisibleLines - 8'd1);
      end else begin
        dot_d = dot_q + 9'd1;
      end
      line_start_d = (dot_d == 9'd0);
`ifdef PPU_VAR_XFER_EN
      xfer_seen_d = 1'b0;
      if (ly_d >= VisibleLines) begin
        mode_d = ModeVblank;
      end else if (dot_d == 9'd0) begin
        mode_d = ModeOamScan;
      end else if (dot_d == OamDots) begin
        mode_d = ModeXfer;
      end else if ((mode_q == ModeXfer) &&
                   (xfer_seen_q || xfer_hit || (dot_d == XferMaxDot))) begin
        mode_d = ModeHblank;
      end
`else
      mode_d = fixed_mode(ly_d, dot_d);
`endif
      oam_d = (mode_d == ModeOamScan) ? dot_d[6:1] : 6'd0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      running_q    <= 1'b0;
      ly_q         <= 8'd0;
      dot_q        <= 9'd0;
      mode_q       <= ModeHblank;
      oam_q        <= 6'd0;
      line_start_q <= 1'b0;
      vblank_q     <= 1'b0;
`ifdef PPU_VAR_XFER_EN
      xfer_seen_q  <= 1'b0;
`endif
    end else begin
      running_q    <= running_d;
      ly_q         <= ly_d;
      dot_q        <= dot_d;
      mode_q       <= mode_d;
      oam_q        <= oam_d;
      line_start_q <= line_start_d;
      vblank_q     <= vblank_d;
`ifdef PPU_VAR_XFER_EN
      xfer_seen_q  <= xfer_seen_d;
`endif
    end
  end

  lcd_timing_controller_stat_irq_gen u_stat_irq_gen (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .tick_i        (tick),
    .mode_i        (mode_d),
    .ly_i          (ly_q),
    .lyc_i         (lyc_i),
    .stat_ie_i     (stat_ie_i),
    .coincidence_o (coincidence_o),
    .stat_irq_o    (stat_irq_o)
  );

  assign ly_o          = ly_q;
  assign mode_o        = mode_q;
  assign dot_x_o       = dot_q;
  assign oam_index_o   = oam_q;
  assign line_start_o  = line_start_q;
  assign vblank_irq_o  = vblank_q;
  assign cpu_vram_ok_o = (mode_q != ModeXfer);
  assign cpu_oam_ok_o  = (mode_q == ModeHblank) || (mode_q == ModeVblank);

endmodule

// File: tb/tb_lcd_timing_controller.sv
// Directed bench for lcd_timing_controller: per-tick position model plus an interrupt scoreboard.
module tb_lcd_timing_controller;

  logic       clk, reset_n, dot_en, lcd_enable, xfer_done;
  logic [3:0] stat_ie;
  logic [7:0] lyc;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       coincidence, line_start, stat_irq, vblank_irq, cpu_vram_ok, cpu_oam_ok;
  logic [8:0] dot_x;
  logic [5:0] oam_index;

  typedef struct packed {
    logic       is_vblank;
    logic [7:0] ly;
    logic [8:0] dot;
  } ev_t;

`ifdef PPU_VAR_XFER_EN
  localparam int HbStart = 369;
`else
  localparam int HbStart = 252;
`endif

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  vblank_seen = 0;
  int  m_ly = 0, m_dot = 0;
  bit  m_run = 0;
  logic exp_coin = 1'b0;

  lcd_timing_controller dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .dot_en_i      (dot_en),
    .lcd_enable_i  (lcd_enable),
    .stat_ie_i     (stat_ie),
    .lyc_i         (lyc),
    .xfer_done_i   (xfer_done),
    .ly_o          (ly),
    .mode_o        (mode),
    .coincidence_o (coincidence),
    .dot_x_o       (dot_x),
    .oam_index_o   (oam_index),
    .line_start_o  (line_start),
    .stat_irq_o    (stat_irq),
    .vblank_irq_o  (vblank_irq),
    .cpu_vram_ok_o (cpu_vram_ok),
    .cpu_oam_ok_o  (cpu_oam_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] mode_of(input int l, input int d);
    if (l >= 144) return 2'd1;
    if (d < 80) return 2'd2;
    if (d < HbStart) return 2'd3;
    return 2'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (ly %0d dot %0d)", tag, obs, exp, m_ly, m_dot);
    end
  endtask

  task automatic push_event(input logic v, input int l, input int d);
    ev_t e;
    e.is_vblank = v;
    e.ly        = 8'(l);
    e.dot       = 9'(d);
    sb.push_back(e);
  endtask

  task automatic pop_event(input logic v);
    ev_t got, want;
    got.is_vblank = v;
    got.ly        = 8'(m_ly);
    got.dot       = 9'(m_dot);
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL irq_unexpected: vblank=%0d at ly %0d dot %0d, none expected", v, m_ly, m_dot);
    end
    if (sb.size() != 0) begin
      want = sb.pop_front();
      check("irq_event", 32'(got), 32'(want));
    end
  endtask

  // One clock: advance the position model from the inputs, then compare every output.
  task automatic step();
    logic        nc, els;
    logic [1:0]  em;
    logic [31:0] obs, exp;
    nc = (m_ly == int'(lyc));
    @(posedge clk);
    #1;
    exp_coin = nc;
    els = 1'b0;
    if (!lcd_enable) begin
      m_run = 0; m_ly = 0; m_dot = 0;
    end else if (dot_en) begin
      if (!m_run) begin
        m_run = 1; m_ly = 0; m_dot = 0;
      end else if (m_dot == 455) begin
        m_dot = 0;
        m_ly  = (m_ly == 153) ? 0 : m_ly + 1;
      end else begin
        m_dot++;
      end
      els = (m_dot == 0);
    end
    em  = m_run ? mode_of(m_ly, m_dot) : 2'd0;
    exp = {3'b0, 8'(m_ly), 9'(m_dot), em, (em == 2'd2) ? 6'(m_dot >> 1) : 6'd0,
           exp_coin, els, em != 2'd3, em < 2'd2};
    obs = {3'b0, ly, dot_x, mode, oam_index, coincidence, line_start, cpu_vram_ok, cpu_oam_ok};
    check("state", obs, exp);
    if (vblank_irq) begin
      vblank_seen++;
      pop_event(1'b1);
    end
    if (stat_irq) pop_event(1'b0);
  endtask

  task automatic run_to(input int l, input int d);
    int n;
    n = 0;
    while (!(m_ly == l && m_dot == d) && n < 80000) begin
      step();
      n++;
    end
    vectors++;
    assert (n < 80000) else begin
      miscompares++;
      $error("FAIL run_to_timeout: at ly %0d dot %0d, wanted ly %0d dot %0d", m_ly, m_dot, l, d);
    end
  endtask

  initial begin
    reset_n = 1'b0; dot_en = 1'b0; lcd_enable = 1'b0; xfer_done = 1'b0;
    stat_ie = 4'b0000; lyc = 8'h45;
    #1;
    check("reset", {3'b0, ly, dot_x, mode, oam_index, coincidence, line_start, cpu_vram_ok,
                    cpu_oam_ok, stat_irq, vblank_irq}, 32'b1100);
    #20 reset_n = 1'b1;
    repeat (3) step();

    // Frame 1: mode boundaries, coincidence, blocking STAT, vblank + STAT together.
    lcd_enable = 1'b1; dot_en = 1'b1;
    push_event(1'b0, 10, HbStart);
    push_event(1'b0, 8'h45, 1);
    push_event(1'b1, 144, 0);
    push_event(1'b0, 144, 0);
    step();
    run_to(0, 5);
    dot_en = 1'b0;
    repeat (3) step();
    dot_en = 1'b1;
    run_to(10, 100);  stat_ie = 4'b0101;
    run_to(11, 100);  stat_ie = 4'b0000;
    run_to(20, 0);    stat_ie = 4'b1000;
    run_to(100, 0);   stat_ie = 4'b1010;
    run_to(153, 455);
    step();
    check("frame_wrap", 32'({ly, dot_x, mode}), 32'({8'd0, 9'd0, 2'd2}));
    check("vblank_count", 32'(vblank_seen), 32'd1);

    // Frame 2: mode-0 STAT, then disable mid-line and re-enable.
    run_to(3, 150);
    lyc = 8'h00; stat_ie = 4'b0001;
    push_event(1'b0, 3, HbStart);
    run_to(3, 300);
    lcd_enable = 1'b0;
    repeat (4) step();
    lcd_enable = 1'b1;
    step();
    check("reenable_mode", 32'(mode), 32'd2);
    run_to(0, 100);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL irq_missing: %0d interrupt events pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
